mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named Clk and Reset.
REQ-002 The block SHALL have parameter DEPTH, default 64: number of 32-bit words stored; a power of two, 2 to 1024.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response; 0 to 15.
REQ-004 The block SHALL have these ports:
- Clk  in  1  clock; rising edge active
- Reset  in  1  synchronous reset, active-high
- Req  in  1  request strobe from the CPU side
- Wr  in  1  1 = write, 0 = read; sampled with Req
- Address  in  32  byte address; sampled with Req
- DataIn  in  32  write data; sampled with Req
- DataOut  out  32  read data; valid while Ack=1 on a read
- Ack  out  1  one-cycle completion pulse
- AddrErr  out  1  error flag; valid while Ack=1
- Busy  out  1  1 whenever the state is not IDLE

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-006 In IDLE with Req=1 at a rising edge, the block SHALL capture Wr, Address and DataIn into internal registers.
REQ-007 On that capture edge, the block SHALL load the wait counter with WAIT_CYCLES.
REQ-008 On that capture edge, the next state SHALL be WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-009 In WAIT, the counter SHALL decrement by 1 per cycle; the edge at which it would reach 0 SHALL move the state to RESP.
REQ-010 RESP SHALL last exactly one cycle, and the state SHALL then always return to IDLE.
REQ-011 Ack SHALL be 1 only in RESP; from capture edge to Ack high SHALL be WAIT_CYCLES+1 cycles.
REQ-012 Req SHALL be ignored in WAIT and RESP; the next request is accepted at the first IDLE edge, so back-to-back period = WAIT_CYCLES+2 cycles.
REQ-013 Word index SHALL be captured Address[log2(DEPTH)+1:2].
REQ-014 A valid write SHALL update the word with the captured DataIn on the edge that enters RESP.
REQ-015 A valid read SHALL load DataOut on the edge that enters RESP.
REQ-016 DataOut SHALL hold its value until the next valid read.
REQ-017 A write SHALL NOT change DataOut.
REQ-018 Wr, Address and DataIn changing after the capture edge SHALL have no effect on the transaction in flight.
REQ-019 Busy SHALL equal (state != IDLE), generated from registered state.

Reset
REQ-020 Reset SHALL take priority over all other inputs at every edge.
REQ-021 On Reset the state SHALL be IDLE, and Ack, AddrErr, Busy, the counter and DataOut SHALL all be 0.
REQ-022 Reset SHALL NOT clear memory contents.
REQ-023 Reset asserted mid-transaction SHALL abort it: no write, no Ack.
REQ-024 A request presented on the edge Reset deasserts SHALL be ignored.

Configuration
REQ-025 Macro MEM_RESPONDER_ADDR_CHECK_EN SHALL compile address checking in or out.
REQ-026 With MEM_RESPONDER_ADDR_CHECK_EN defined, a request SHALL be an error when Address[1:0]!=0 or any Address bit above the index field is 1.
REQ-027 An error request SHALL take the same latency as a valid one, assert Ack=1 and AddrErr=1 in RESP, perform no write, and leave DataOut unchanged.
REQ-028 Without MEM_RESPONDER_ADDR_CHECK_EN, Address[1:0] and the upper bits SHALL be ignored, addresses SHALL wrap modulo DEPTH words, and AddrErr SHALL be tied to 0.

Verification
REQ-029 Defaults, write then read: write Address=0x10, DataIn=0xDEADBEEF, then read Address=0x10 -> each Ack arrives 3 cycles after capture; the read returns DataOut=0xDEADBEEF with AddrErr=0.
REQ-030 Latency sweep over WAIT_CYCLES=0, 1, 15 -> Ack 1, 2, 16 cycles after capture; Busy high from capture until Ack falls.
REQ-031 Req held high continuously, WAIT_CYCLES=2 -> one transaction accepted every 4 cycles; Address changes during WAIT are ignored.
REQ-032 With the macro enabled, read 0x13 and write 0x100 (DEPTH=64) -> Ack=1 with AddrErr=1; word 0 is unchanged and DataOut keeps its previous value.
REQ-033 With the macro disabled, write 0x100 with data 0x1234 -> word 0 becomes 0x1234 and AddrErr=0.
REQ-034 Reset one cycle after capturing a write of 0x55 to word 5 -> no Ack, word 5 keeps its old value, and all outputs are 0 the next cycle.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory that answers each request after WAIT_CYCLES wait states.
// Optional address checking is compiled in by defining MEM_RESPONDER_ADDR_CHECK_EN.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        AddrErr,
  output logic        Busy
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_next_s;
  logic             capture_s;

  logic             wr_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      data_r;
  logic             err_r;

  logic [IDX_W-1:0] idx_in_s;
  logic             err_in_s;

  logic             txn_wr_s;
  logic [IDX_W-1:0] txn_idx_s;
  logic [31:0]      txn_data_s;
  logic             txn_err_s;

  logic             enter_resp_s;
  logic             mem_we_s;
  logic             rd_ld_s;

  logic [31:0]      mem_r [DEPTH];
  logic [31:0]      data_out_r;
  logic             ack_r;
  logic             addr_err_r;
  logic             busy_r;

  assign idx_in_s = Address[IDX_W+1:2];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  // Misaligned, or any bit set above the word-index field.
  function automatic logic addr_bad_f(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> (IDX_W + 2)) != 32'd0);
  endfunction

  assign err_in_s = addr_bad_f(Address);
`else
  logic unused_addr_s;
  assign unused_addr_s = ^{Address[1:0], Address[31:IDX_W+2]};
  assign err_in_s      = 1'b0;
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Req) begin
          capture_s  = 1'b1;
          cnt_next_s = WAIT_LOAD;
          if (HAS_WAIT) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_RESP;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          cnt_next_s   = 4'd0;
          state_next_s = ST_RESP;
        end else begin
          cnt_next_s   = cnt_r - 4'd1;
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // A zero-wait request enters RESP on its own capture edge, so it acts on the live inputs.
  always_comb begin
    if (capture_s) begin
      txn_wr_s   = Wr;
      txn_idx_s  = idx_in_s;
      txn_data_s = DataIn;
      txn_err_s  = err_in_s;
    end else begin
      txn_wr_s   = wr_r;
      txn_idx_s  = idx_r;
      txn_data_s = data_r;
      txn_err_s  = err_r;
    end
  end

  assign enter_resp_s = (state_next_s == ST_RESP) && !Reset;
  assign mem_we_s     = enter_resp_s && txn_wr_s && !txn_err_s;
  assign rd_ld_s      = enter_resp_s && !txn_wr_s && !txn_err_s;

  // Control state, captured request and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      wr_r       <= 1'b0;
      idx_r      <= '0;
      data_r     <= 32'd0;
      err_r      <= 1'b0;
      data_out_r <= 32'd0;
      ack_r      <= 1'b0;
      addr_err_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      ack_r      <= enter_resp_s;
      addr_err_r <= enter_resp_s && txn_err_s;
      busy_r     <= (state_next_s != ST_IDLE);
      if (capture_s) begin
        wr_r   <= Wr;
        idx_r  <= idx_in_s;
        data_r <= DataIn;
        err_r  <= err_in_s;
      end
      if (rd_ld_s) begin
        data_out_r <= mem_r[txn_idx_s];
      end
    end
  end

  // Storage array; contents deliberately survive Reset.
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem_r[txn_idx_s] <= txn_data_s;
    end
  end

  assign DataOut = data_out_r;
  assign Ack     = ack_r;
  assign AddrErr = addr_err_r;
  assign Busy    = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (WAIT_CYCLES 2, 0, 1, 15) share one stimulus and are
// checked every cycle against a timer-based transaction model, plus hand-computed expectations.
module tb_mem_responder;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic          req;
  logic          wr;
  logic [31:0]   addr;
  logic [31:0]   din;
  logic [31:0]   dout [N];
  logic [N-1:0]  ack;
  logic [N-1:0]  aerr;
  logic [N-1:0]  busy;

  int checks;
  int errors;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Address(addr), .DataIn(din),
    .DataOut(dout[0]), .Ack(ack[0]), .AddrErr(aerr[0]), .Busy(busy[0]));
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Address(addr), .DataIn(din),
    .DataOut(dout[1]), .Ack(ack[1]), .AddrErr(aerr[1]), .Busy(busy[1]));
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(1)) dut2 (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Address(addr), .DataIn(din),
    .DataOut(dout[2]), .Ack(ack[2]), .AddrErr(aerr[2]), .Busy(busy[2]));
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(15)) dut3 (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Address(addr), .DataIn(din),
    .DataOut(dout[3]), .Ack(ack[3]), .AddrErr(aerr[3]), .Busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: each accepted request keeps the block busy for WAIT+1 cycles, the last one acknowledged.
  int          m_left  [N];
  logic        m_wr    [N];
  logic [5:0]  m_idx   [N];
  logic [31:0] m_data  [N];
  logic        m_err   [N];
  logic [31:0] m_dout  [N];
  logic [31:0] m_mem   [N][64];
  int          cap_cyc [N];
  int          seen_cap[N];
  int          lat_obs [N];
  int          ack_cnt [N];
  int          aerr_cnt[N];
  int          cyc;

  initial begin
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      m_left[k]   = 0;
      m_dout[k]   = 32'd0;
      cap_cyc[k]  = -1;
      seen_cap[k] = -1;
      lat_obs[k]  = -1;
      ack_cnt[k]  = 0;
      aerr_cnt[k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (rst) begin
          m_left[k] = 0;
          m_dout[k] = 32'd0;
        end else if (m_left[k] == 0) begin
          if (req) begin
            m_wr[k]    = wr;
            m_idx[k]   = addr[7:2];
            m_data[k]  = din;
            m_err[k]   = addr_bad(addr);
            m_left[k]  = wait_of(k) + 1;
            cap_cyc[k] = cyc;
          end
        end else begin
          m_left[k]--;
        end
        if (!rst && m_left[k] == 1 && !m_err[k]) begin
          if (m_wr[k]) m_mem[k][m_idx[k]] = m_data[k];
          else         m_dout[k] = m_mem[k][m_idx[k]];
        end
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check($sformatf("ack[%0d]@%0d", k, cyc), 32'(ack[k]), 32'(m_left[k] == 1));
        check($sformatf("busy[%0d]@%0d", k, cyc), 32'(busy[k]), 32'(m_left[k] > 0));
        check($sformatf("addrerr[%0d]@%0d", k, cyc), 32'(aerr[k]), 32'(m_left[k] == 1 && m_err[k]));
        check($sformatf("dataout[%0d]@%0d", k, cyc), dout[k], m_dout[k]);
        if (ack[k] === 1'b1) begin
          ack_cnt[k]++;
          if (aerr[k] === 1'b1) aerr_cnt[k]++;
          if (seen_cap[k] != cap_cyc[k]) begin
            lat_obs[k]  = cyc - cap_cyc[k] + 1;
            seen_cap[k] = cap_cyc[k];
          end
        end
      end
    end
  end

  // One request pulse; the inputs are scrambled right after capture and the bench idles until all instances finish.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    req  = 1'b1;
    wr   = w;
    addr = a;
    din  = d;
    @(negedge clk);
    req  = 1'b0;
    wr   = ~w;
    addr = ~a;
    din  = ~d;
    repeat (18) @(negedge clk);
  endtask

  function automatic logic [31:0] held_addr(input int i);
    case (i)
      0:       return 32'h0000_0010;
      1:       return 32'h0000_0000;
      default: return 32'h0000_0014;
    endcase
  endfunction

  int base[N];

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    req  = 1'b0;
    wr   = 1'b0;
    addr = 32'd0;
    din  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_dataout", dout[0], 32'd0);
    check("reset_ack", 32'(ack[0]), 32'd0);
    check("reset_busy", 32'(busy[0]), 32'd0);

    // Request presented while Reset is still high is ignored.
    req  = 1'b1;
    wr   = 1'b1;
    addr = 32'h0000_0010;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("req_during_reset_busy", 32'(busy[0]), 32'd0);

    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("lat_wait2", 32'(lat_obs[0]), 32'd3);
    check("lat_wait0", 32'(lat_obs[1]), 32'd1);
    check("lat_wait1", 32'(lat_obs[2]), 32'd2);
    check("lat_wait15", 32'(lat_obs[3]), 32'd16);
    check("write_keeps_dataout", dout[0], 32'd0);

    txn(1'b0, 32'h0000_0010, 32'h0);
    check("read_0x10", dout[0], 32'hDEAD_BEEF);
    check("read_0x10_w15", dout[3], 32'hDEAD_BEEF);

    txn(1'b1, 32'h0000_0000, 32'hCAFE_0000);
    txn(1'b1, 32'h0000_0014, 32'hAAAA_0005);
    txn(1'b1, 32'h0000_003C, 32'h0F0F_0F0F);
    txn(1'b0, 32'h0000_003C, 32'h0);
    check("read_0x3c", dout[0], 32'h0F0F_0F0F);

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    txn(1'b0, 32'h0000_0013, 32'h0);
    check("misaligned_read_keeps_dataout", dout[0], 32'h0F0F_0F0F);
    txn(1'b1, 32'h0000_0100, 32'h0000_1234);
    check("addrerr_pulses", 32'(aerr_cnt[0]), 32'd2);
    txn(1'b0, 32'h0000_0000, 32'h0);
    check("word0_unchanged", dout[0], 32'hCAFE_0000);
`else
    txn(1'b1, 32'h0000_0100, 32'h0000_1234);
    txn(1'b0, 32'h0000_0000, 32'h0);
    check("wrapped_write_word0", dout[0], 32'h0000_1234);
    txn(1'b0, 32'h0000_0017, 32'h0);
    check("low_bits_ignored", dout[0], 32'hAAAA_0005);
    check("addrerr_never", 32'(aerr_cnt[0]), 32'd0);
`endif

    // Req held high for 12 edges while the address keeps changing.
    for (int k = 0; k < N; k++) base[k] = ack_cnt[k];
    wr  = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      addr = held_addr(i % 3);
      din  = 32'h0BAD_0000 + 32'(i);
      @(negedge clk);
    end
    req = 1'b0;
    repeat (18) @(negedge clk);
    check("held_req_acks_wait2", 32'(ack_cnt[0] - base[0]), 32'd3);
    check("held_req_acks_wait0", 32'(ack_cnt[1] - base[1]), 32'd6);
    check("held_req_acks_wait1", 32'(ack_cnt[2] - base[2]), 32'd4);
    check("held_req_acks_wait15", 32'(ack_cnt[3] - base[3]), 32'd1);
    check("held_req_last_read", dout[0], 32'hAAAA_0005);

    // Reset one cycle after capturing a write of 0x55 to word 5.
    base[0] = ack_cnt[0];
    req  = 1'b1;
    wr   = 1'b1;
    addr = 32'h0000_0014;
    din  = 32'h0000_0055;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ack", 32'(ack[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_addrerr", 32'(aerr[0]), 32'd0);
    check("abort_dataout", dout[0], 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt[0] - base[0]), 32'd0);
    txn(1'b0, 32'h0000_0014, 32'h0);
    check("abort_word5_kept", dout[0], 32'hAAAA_0005);
    check("wait0_write_done_before_reset", dout[1], 32'h0000_0055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
